// File: rtl/timer_unit.sv
// Prescaled 16-bit timer behind the TCON/TMR register pair.
// Supports one-shot and auto-reload modes, edge-triggered clear, a terminal-count irq pulse and a done level.
module timer_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tmr_ctrl,
  output logic [15:0] tmr_cntr,
  output logic        tmr_irq,
  output logic        tmr_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] cntr_reg, cntr_next;
  logic [15:0] psc_reg, psc_next;
  logic        irq_reg, irq_next;
  logic        done_reg;
  logic        clr_q_reg;

  logic        en, mode, irq_en, clr;
  logic [3:0]  psc_exp;
  logic [15:0] period;
  logic [15:0] psc_mask;
  logic        clr_edge, tick, at_period;
  logic        unused_rsvd;

  assign en          = tmr_ctrl[0];
  assign mode        = tmr_ctrl[1];
  assign irq_en      = tmr_ctrl[2];
  assign clr         = tmr_ctrl[3];
  assign psc_exp     = tmr_ctrl[7:4];
  assign period      = tmr_ctrl[31:16];
  assign unused_rsvd = ^tmr_ctrl[15:8];

  // mask = 2^p - 1: bit gi is set whenever gi lies below the exponent
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mask
      assign psc_mask[gi] = (psc_exp > 4'(gi));
    end
  endgenerate

  assign clr_edge  = clr && !clr_q_reg;
  assign tick      = (state_reg == ST_RUN) && ((psc_reg & psc_mask) == psc_mask);
  assign at_period = (cntr_reg == period);

  always_comb begin
    state_next = state_reg;
    cntr_next  = cntr_reg;
    psc_next   = 16'd0;
    irq_next   = 1'b0;

    if (clr_edge) begin
      cntr_next  = 16'd0;
      state_next = en ? ST_RUN : ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (en) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            state_next = ST_IDLE;
          end else begin
            psc_next = psc_reg + 16'd1;
            if (tick) begin
              if (!at_period) begin
                cntr_next = cntr_reg + 16'd1;
              end else begin
                irq_next = irq_en;
                if (mode) cntr_next  = 16'd0;
                else      state_next = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          // dropping EN re-arms the one-shot from zero
          if (!en) begin
            state_next = ST_IDLE;
            cntr_next  = 16'd0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cntr_next  = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cntr_reg  <= 16'd0;
      psc_reg   <= 16'd0;
      irq_reg   <= 1'b0;
      done_reg  <= 1'b0;
      clr_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cntr_reg  <= cntr_next;
      psc_reg   <= psc_next;
      irq_reg   <= irq_next;
      done_reg  <= (state_next == ST_DONE);
      clr_q_reg <= clr;
    end
  end

  assign tmr_cntr = cntr_reg;
  assign tmr_irq  = irq_reg;
  assign tmr_done = done_reg;

endmodule

// File: doc/timer_unit.md
# timer_unit

Hardware timer for the single-cycle MIPS core, at the far end of the timer register interface. Each clock it samples the 32-bit timer control word (`TCON` register contents from the register file). It runs a prescaled 16-bit up-counter and returns the live count on `tmr_cntr`, which software reads through the `TMR` register address. It also raises a terminal-count interrupt pulse and a one-shot done flag.

## Interface
- No parameters; all widths are fixed by the register file interface.
- `clk`: input, 1 bit. System clock. All state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `tmr_ctrl`: input, 32 bits. `TCON` word. The register file writes it on the falling edge; this block samples it on the rising edge.
  - [0] `EN`
  - [1] `MODE` (0 one-shot, 1 auto-reload)
  - [2] `IRQ_EN`
  - [3] `CLR`
  - [7:4] `PSC` exponent p
  - [15:8] reserved, ignored
  - [31:16] `PERIOD`
- `tmr_cntr`: output, 16 bits. Current count, registered.
- `tmr_irq`: output, 1 bit. One-cycle pulse at terminal count when `IRQ_EN`=1.
- `tmr_done`: output, 1 bit. Level; high while in DONE.

## Operation
- **Reset values:** state IDLE, `tmr_cntr`=0, prescaler `psc`=0, `tmr_irq`=0, `tmr_done`=0, `clr_q` (previous `CLR` sample)=0.
- **Prescaler:**
  - 16-bit `psc` is free-running while in RUN and is cleared in any other state.
  - `tick` = RUN && ((`psc` & mask) == mask), where mask = 2^p − 1.
  - p=0 gives a tick every clock; p=15 gives one tick per 32768 clocks.
  - A change of p takes effect immediately; no reset of `psc` is needed.
- **Clear:** `clr_edge` = `CLR` && !`clr_q`. It has highest priority:
  - `tmr_cntr`←0 and `psc`←0.
  - Next state is RUN if `EN`=1, else IDLE.
  - No increment or irq occurs in that cycle.
  - A `CLR` held at 1 acts only once.
- **States:**
  - **IDLE:**
    - `EN`=1 → RUN.
    - Otherwise hold: the counter is frozen, so leaving RUN via `EN`=0 is a pause.
  - **RUN:**
    - `EN`=0 → IDLE, keeping `tmr_cntr`.
    - On `tick` with `tmr_cntr` != `PERIOD`: `tmr_cntr`←`tmr_cntr`+1, mod 2^16.
    - On `tick` with `tmr_cntr` == `PERIOD` (terminal count): `tmr_irq`←`IRQ_EN`.
      - `MODE`=1: `tmr_cntr`←0 and stay in RUN.
      - `MODE`=0: `tmr_cntr` holds at `PERIOD` and the block goes to DONE.
  - **DONE:**
    - `tmr_done`=1 and the counter is held.
    - `EN`=0 → IDLE with `tmr_cntr`←0, which re-arms the one-shot.
    - `clr_edge` → RUN (if `EN`=1) from 0.
    - A `MODE` change while in DONE has no effect until re-armed.
- **Boundary cases:**
  - `PERIOD`=0: every tick is terminal.
    - Auto-reload: the count stays 0 and `tmr_irq` pulses every tick.
    - One-shot: DONE on the first tick.
  - `PERIOD` written below the current count: counting continues to 0xFFFF, wraps to 0 with no irq, then reaches `PERIOD` normally.
  - `PERIOD`=0xFFFF: terminal at 0xFFFF, never wraps.
  - `IRQ_EN` cleared: terminal-count behaviour is unchanged; only the pulse is suppressed.
- Reserved bits [15:8] have no effect.

## Timing
- All outputs are registered; there is no combinational path from `tmr_ctrl` to any output.
- **Start latency:** `EN` sampled 1 at rising edge k gives RUN after k. With p=0, the first increment is at edge k+1, so `tmr_cntr`=1 is visible after k+1.
- **Stop:** `EN` sampled 0 at edge k means no increment at k; the state is IDLE after k.
- **Terminal count:** `tmr_irq` is high for exactly the one cycle following the terminal-count edge. `tmr_done` rises on that same edge.
- **Clear:** `clr_edge` is sampled at edge k; `tmr_cntr`=0 after k.
- A software write to `TCON` lands on a falling edge and is acted on at the next rising edge, giving one-cycle write-to-effect latency.
- **Asynchronous reset:** assertion forces all reset values immediately. It is legal mid-count and mid-irq pulse; no pulse is emitted after reset is released.

## Test plan
- **Reset mid-count:** auto-reload, p=0, `PERIOD`=5, `EN`=1; assert `rst` at count 3 → outputs 0 immediately, and counting resumes from 0 one edge after release.
- **Auto-reload with prescaler:** `TCON`=0x0004_0027 (`PERIOD`=4, p=2, `IRQ_EN`, `MODE`=1, `EN`) → count steps 0,1,2,3,4,0 every 4 clocks; `tmr_irq` is a single-cycle pulse every 20 clocks.
- **One-shot:** `TCON`=0x0003_0005 → counts to 3, `tmr_done`=1, count held at 3 with no further pulses. `EN`=0 then `EN`=1 gives count 0 and a restart.
- **Pause/resume and clear:** p=0; drop `EN` at count 7 → holds at 7 for 10 clocks; re-enable → 8 on the 2nd edge. Set `CLR` with `EN`=1 → count 0 after one edge; `CLR` held high has no further effect.
- **Edge cases:** `PERIOD`=0, auto-reload, p=0 → count stays 0 and `tmr_irq` is high every cycle. `PERIOD` lowered from 100 to 2 at count 50 → wraps 0xFFFF→0 with no irq, then irq at 2.
